// File: rtl/keccak_pkg.sv
// Shared Keccak constants: mode encodings, per-mode rate/word counts, padding bytes.
package keccak_pkg;

  localparam int unsigned W     = 64;
  localparam int unsigned BLK   = 1344;
  localparam int unsigned NSLOT = BLK / W;
  localparam int unsigned CNT_W = 5;

  localparam int unsigned RATE_M0 = 576;
  localparam int unsigned RATE_M1 = 1088;
  localparam int unsigned RATE_M2 = 1344;
  localparam int unsigned RATE_M3 = 1088;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_FINAL    = 8'h80;

  typedef enum logic [1:0] {
    MODE_SHA3_512 = 2'd0,
    MODE_SHA3_256 = 2'd1,
    MODE_SHAKE128 = 2'd2,
    MODE_SHAKE256 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] words_per_block(input mode_e m);
    case (m)
      MODE_SHA3_512: words_per_block = CNT_W'(RATE_M0 / W);
      MODE_SHA3_256: words_per_block = CNT_W'(RATE_M1 / W);
      MODE_SHAKE128: words_per_block = CNT_W'(RATE_M2 / W);
      MODE_SHAKE256: words_per_block = CNT_W'(RATE_M3 / W);
      default:       words_per_block = CNT_W'(RATE_M0 / W);
    endcase
  endfunction

  function automatic logic [7:0] domain_byte(input mode_e m);
    case (m)
      MODE_SHAKE128, MODE_SHAKE256: domain_byte = DOMAIN_SHAKE;
      default:                      domain_byte = DOMAIN_SHA3;
    endcase
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Builds the final message word: valid bytes, domain byte, zeros, and the
// closing 0x80 bit when the word lands in the last slot of the rate.
module keccak_pad_word
  import keccak_pkg::*;
(
  input  logic [W-1:0] i_in,
  input  logic [2:0]   i_byte_num,
  input  logic [7:0]   i_domain,
  input  logic         i_final_slot,
  output logic [W-1:0] o_word_c
);

  always_comb begin
    o_word_c = '0;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) < i_byte_num) begin
        o_word_c[W-1-8*k -: 8] = i_in[W-1-8*k -: 8];
      end else if (3'(k) == i_byte_num) begin
        o_word_c[W-1-8*k -: 8] = i_domain;
      end
    end
    // Byte 7 may already hold the domain byte; OR keeps both (0x86 / 0x9F).
    if (i_final_slot) begin
      o_word_c[7:0] = o_word_c[7:0] | PAD_FINAL;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Collects 64-bit message words into a rate-sized block, applies multi-rate
// padding, and hands the block to the permutation with a ready/ack handshake.
module keccak_padder
  import keccak_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [W-1:0]      in,
  input  logic              in_ready,
  input  logic              is_last,
  input  logic [2:0]        byte_num,
  input  logic              f_ack,
  output logic              buffer_full,
  output logic [BLK-1:0]    out,
  output logic              out_ready,
  output logic              last_block
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  mode_e            r_mode;
  logic             r_msg_active;
  logic [BLK-1:0]   r_out;
  logic             r_out_ready;
  logic             r_last_block;
  logic             r_buffer_full;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wr_en;
  logic [W-1:0]     w_wr_data;
  logic             w_clr_out;
  logic             w_last_nxt;
  logic             w_msg_nxt;
  mode_e            w_mode;
  logic [CNT_W-1:0] w_words;
  logic             w_final_slot;
  logic [7:0]       w_domain;
  logic [W-1:0]     w_pad_word;
  logic             w_mode_latch;

  // Mode follows the port until the first word of a message is taken, then it is frozen.
  always_comb begin
    w_mode       = r_msg_active ? r_mode : mode_e'(mode);
    w_words      = words_per_block(w_mode);
    w_domain     = domain_byte(w_mode);
    w_final_slot = (r_cnt == (w_words - CNT_W'(1)));
    w_mode_latch = (r_state == ST_ABSORB) && in_ready && !r_msg_active;
  end

  keccak_pad_word u_pad_word (
    .i_in         (in),
    .i_byte_num   (byte_num),
    .i_domain     (w_domain),
    .i_final_slot (w_final_slot),
    .o_word_c     (w_pad_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ABSORB;
      r_cnt         <= '0;
      r_msg_active  <= 1'b0;
      r_last_block  <= 1'b0;
      r_out_ready   <= 1'b0;
      r_buffer_full <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_msg_active  <= w_msg_nxt;
      r_last_block  <= w_last_nxt;
      r_out_ready   <= (w_state_nxt == ST_FULL);
      r_buffer_full <= (w_state_nxt != ST_ABSORB);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    w_clr_out   = 1'b0;
    w_last_nxt  = r_last_block;
    w_msg_nxt   = r_msg_active;
    case (r_state)
      ST_ABSORB: begin
        if (in_ready) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_msg_nxt = 1'b1;
          if (is_last) begin
            w_wr_data = w_pad_word;
            if (w_final_slot) begin
              w_state_nxt = ST_FULL;
              w_last_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_PAD;
            end
          end else begin
            w_wr_data = in;
            if (w_final_slot) begin
              w_state_nxt = ST_FULL;
              w_last_nxt  = 1'b0;
            end
          end
        end
      end
      ST_PAD: begin
        w_wr_en   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_final_slot) begin
          w_wr_data   = W'(PAD_FINAL);
          w_state_nxt = ST_FULL;
          w_last_nxt  = 1'b1;
        end
      end
      ST_FULL: begin
        if (f_ack) begin
          w_state_nxt = ST_ABSORB;
          w_cnt_nxt   = '0;
          w_clr_out   = 1'b1;
          w_last_nxt  = 1'b0;
          // A padded block closes the message; the next word starts a new one.
          if (r_last_block) begin
            w_msg_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ABSORB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= MODE_SHA3_512;
    end else if (w_mode_latch) begin
      r_mode <= mode_e'(mode);
    end
  end

  // Block register: slot cnt occupies out[BLK-1-W*cnt -: W].
  always_ff @(posedge clk) begin
    if (reset || w_clr_out) begin
      r_out <= '0;
    end else if (w_wr_en) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (r_cnt == CNT_W'(s)) begin
          r_out[BLK-1-W*s -: W] <= w_wr_data;
        end
      end
    end
  end

  assign out         = r_out;
  assign out_ready   = r_out_ready;
  assign last_block  = r_last_block;
  assign buffer_full = r_buffer_full;

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder: directed vector table, multi-cycle
// corner sequences, and random messages checked against a byte-level padding model.
module tb_keccak_padder;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [63:0]   in;
  logic          in_ready;
  logic          is_last;
  logic [2:0]    byte_num;
  logic          f_ack;
  logic          buffer_full;
  logic [1343:0] out;
  logic          out_ready;
  logic          last_block;

  always #5 clk = ~clk;

  keccak_padder dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .f_ack       (f_ack),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .last_block  (last_block)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    g_msg[$];
  logic [1343:0] g_exp_blk[$];
  logic          g_exp_last[$];
  logic [1343:0] g_cap[$];
  logic          g_cap_last[$];

  typedef struct {
    logic [1:0]  m;
    logic [1:0]  m2;
    int          nfull;
    logic [63:0] fill;
    logic [63:0] lw;
    logic [2:0]  bn;
    int          blk;
    int          slot;
    logic [63:0] exp_word;
    logic        exp_last;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1343:0] act, input logic [1343:0] exp);
    int bad;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      bad = -1;
      for (int s = 0; s < 21; s++) begin
        if (bad < 0 && act[1343-64*s -: 64] !== exp[1343-64*s -: 64]) bad = s;
      end
      $display("FAIL %s: slot %0d got %h, want %h", name, bad,
               act[1343-64*bad -: 64], exp[1343-64*bad -: 64]);
    end
  endtask

  // Reference: byte-stream padding (msg || domain || 0* with 0x80 in the last rate byte).
  task automatic model_blocks(input logic [1:0] m);
    int rb;
    int nb;
    logic [7:0] dom;
    logic [7:0] p[$];
    logic [1343:0] blk;
    rb  = (m == 2'd0) ? 72 : (m == 2'd2) ? 168 : 136;
    dom = m[1] ? 8'h1F : 8'h06;
    p = g_msg;
    p.push_back(dom);
    while ((p.size() % rb) != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nb = p.size() / rb;
    g_exp_blk.delete();
    g_exp_last.delete();
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < rb; i++) blk[1343-8*i -: 8] = p[b*rb+i];
      g_exp_blk.push_back(blk);
      g_exp_last.push_back(b == nb - 1);
    end
  endtask

  task automatic send_word(input logic [63:0] w, input logic l, input logic [2:0] bn,
                           input logic [1:0] m);
    int t;
    logic bf;
    t = 0;
    in = w; is_last = l; byte_num = bn; mode = m; in_ready = 1'b1;
    do begin
      bf = buffer_full;
      @(posedge clk); #1;
      t++;
    end while (bf && t < 2000);
    if (bf) begin
      n_checks++; n_fail++;
      $display("FAIL word_accept_timeout: buffer_full stuck at %b, want 0", bf);
    end
    in_ready = 1'b0;
    in = {$urandom, $urandom};
    is_last = 1'(($urandom % 2));
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic drive_msg(input logic [1:0] m, input logic [1:0] m_later);
    int nw;
    int bn;
    logic [63:0] w;
    nw = g_msg.size() / 8;
    bn = g_msg.size() % 8;
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 8; k++) w[63-8*k -: 8] = g_msg[8*i+k];
      send_word(w, 1'b0, 3'd0, (i == 0) ? m : m_later);
    end
    w = {$urandom, $urandom};
    for (int k = 0; k < bn; k++) w[63-8*k -: 8] = g_msg[8*nw+k];
    send_word(w, 1'b1, 3'(bn), (nw == 0) ? m : m_later);
  endtask

  task automatic collect();
    int t;
    logic [1343:0] hold;
    for (int k = 0; k < g_exp_blk.size(); k++) begin
      t = 0;
      while (!out_ready && t < 3000) begin @(posedge clk); #1; t++; end
      if (!out_ready) begin
        n_checks++; n_fail++;
        $display("FAIL block_timeout: out_ready %b, want 1 for block %0d", out_ready, k);
        return;
      end
      chk_blk("block", out, g_exp_blk[k]);
      chk("last_block", 64'(last_block), 64'(g_exp_last[k]));
      g_cap.push_back(out);
      g_cap_last.push_back(last_block);
      hold = out;
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
        chk_blk("hold_stable", out, hold);
        chk("hold_bf", 64'(buffer_full), 64'd1);
      end
      f_ack = 1'b1;
      @(posedge clk); #1;
      f_ack = 1'b0;
      chk("ack_ready", 64'(out_ready), 64'd0);
      chk("ack_bf", 64'(buffer_full), 64'd0);
      chk_blk("ack_clear", out, '0);
    end
  endtask

  task automatic run_msg(input logic [1:0] m, input logic [1:0] m_later);
    model_blocks(m);
    g_cap.delete();
    g_cap_last.delete();
    fork
      drive_msg(m, m_later);
      collect();
    join
  endtask

  task automatic do_reset();
    reset = 1'b1; in_ready = 1'b0; f_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time %0t exceeded, want finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [1343:0] hold;
    logic [63:0]   w;
    int            len;
    logic [1:0]    m;

    tbl[0]  = '{2'd1, 2'd1, 0,  64'h0, 64'h0, 3'd0, 0, 0,  64'h0600000000000000, 1'b1};
    tbl[1]  = '{2'd1, 2'd1, 0,  64'h0, 64'h0, 3'd0, 0, 16, 64'h0000000000000080, 1'b1};
    tbl[2]  = '{2'd0, 2'd0, 8,  64'h1111111111111111, 64'h0, 3'd0, 0, 8, 64'h0600000000000080, 1'b1};
    tbl[3]  = '{2'd0, 2'd0, 8,  64'h1111111111111111, 64'h0, 3'd0, 0, 7, 64'h1111111111111111, 1'b1};
    tbl[4]  = '{2'd3, 2'd3, 0,  64'h0, 64'hAABBCCDDEEFF0011, 3'd3, 0, 0, 64'hAABBCC1F00000000, 1'b1};
    tbl[5]  = '{2'd2, 2'd2, 20, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 3'd7, 0, 20, 64'hFEDCBA987654329F, 1'b1};
    tbl[6]  = '{2'd0, 2'd0, 8,  64'h2222222222222222, 64'hDEADBEEFCAFEBAFF, 3'd7, 0, 8, 64'hDEADBEEFCAFEBA86, 1'b1};
    tbl[7]  = '{2'd2, 2'd2, 21, 64'h5555555555555555, 64'h0, 3'd0, 0, 20, 64'h5555555555555555, 1'b0};
    tbl[8]  = '{2'd2, 2'd2, 21, 64'h5555555555555555, 64'h0, 3'd0, 1, 0,  64'h1F00000000000000, 1'b1};
    tbl[9]  = '{2'd2, 2'd2, 21, 64'h5555555555555555, 64'h0, 3'd0, 1, 20, 64'h0000000000000080, 1'b1};
    tbl[10] = '{2'd1, 2'd0, 17, 64'hA5A5A5A5A5A5A5A5, 64'h0, 3'd0, 0, 16, 64'hA5A5A5A5A5A5A5A5, 1'b0};
    tbl[11] = '{2'd1, 2'd0, 17, 64'hA5A5A5A5A5A5A5A5, 64'h0, 3'd0, 1, 0,  64'h0600000000000000, 1'b1};

    reset = 1'b1; mode = 2'd0; in = '0; in_ready = 1'b0; is_last = 1'b0;
    byte_num = 3'd0; f_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_blk("rst_out", out, '0);
    chk("rst_out_ready", 64'(out_ready), 64'd0);
    chk("rst_last_block", 64'(last_block), 64'd0);
    chk("rst_buffer_full", 64'(buffer_full), 64'd0);

    // Directed vector table.
    for (int v = 0; v < 12; v++) begin
      g_msg.delete();
      w = tbl[v].fill;
      for (int i = 0; i < tbl[v].nfull; i++)
        for (int k = 0; k < 8; k++) g_msg.push_back(w[63-8*k -: 8]);
      w = tbl[v].lw;
      for (int k = 0; k < int'(tbl[v].bn); k++) g_msg.push_back(w[63-8*k -: 8]);
      run_msg(tbl[v].m, tbl[v].m2);
      if (tbl[v].blk < g_cap.size()) begin
        hold = g_cap[tbl[v].blk];
        chk($sformatf("vec%0d_slot%0d", v, tbl[v].slot), hold[1343-64*tbl[v].slot -: 64], tbl[v].exp_word);
        chk($sformatf("vec%0d_last", v), 64'(g_cap_last[tbl[v].blk]), 64'(tbl[v].exp_last));
      end else begin
        n_checks++; n_fail++;
        $display("FAIL vec%0d_missing: got %0d blocks, want > %0d", v, g_cap.size(), tbl[v].blk);
      end
    end

    // Empty message, mode 1: exact latency, hold in FULL, ack and re-accept timing.
    do_reset();
    g_msg.delete();
    model_blocks(2'd1);
    mode = 2'd1; in = {$urandom, $urandom}; is_last = 1'b1; byte_num = 3'd0; in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    chk("pad_bf", 64'(buffer_full), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("lat_not_ready", 64'(out_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("lat_ready", 64'(out_ready), 64'd1);
    chk("lat_last", 64'(last_block), 64'd1);
    chk_blk("empty_blk", out, g_exp_blk[0]);
    hold = out;
    for (int i = 0; i < 5; i++) begin
      in_ready = 1'($urandom % 2); is_last = 1'b0; in = {$urandom, $urandom};
      @(posedge clk); #1;
      chk_blk("full_hold", out, hold);
      chk("full_ready", 64'(out_ready), 64'd1);
    end
    in_ready = 1'b0; f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
    chk("post_ack_ready", 64'(out_ready), 64'd0);
    chk("post_ack_bf", 64'(buffer_full), 64'd0);
    w = 64'h0123456789ABCDEF;
    in = w; is_last = 1'b0; in_ready = 1'b1; mode = 2'd0;
    @(posedge clk); #1;
    in_ready = 1'b0;
    chk("reaccept_slot0", out[1343 -: 64], w);
    chk("reaccept_bf", 64'(buffer_full), 64'd0);

    // Reset while padding discards the block.
    do_reset();
    mode = 2'd2; in = {$urandom, $urandom}; is_last = 1'b1; byte_num = 3'd0; in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("in_pad_bf", 64'(buffer_full), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_blk("pad_rst_out", out, '0);
    chk("pad_rst_ready", 64'(out_ready), 64'd0);
    chk("pad_rst_bf", 64'(buffer_full), 64'd0);
    chk("pad_rst_last", 64'(last_block), 64'd0);
    g_msg.delete();
    for (int i = 0; i < 5; i++) g_msg.push_back(8'($urandom));
    run_msg(2'd0, 2'd3);

    // Random messages against the padding model.
    for (int n = 0; n < 25; n++) begin
      m = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 360);
      g_msg.delete();
      for (int i = 0; i < len; i++) g_msg.push_back(8'($urandom));
      run_msg(m, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
